// File: rtl/cam_pkg.sv
// Shared definitions for the SCCB camera configuration block: register map,
// STATUS layout, init-table end marker and sequencer state encodings.
package cam_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_START = 0;
  localparam int CTRL_PWDN  = 1;
  localparam int CTRL_RST   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_DROP    = 2;
  localparam int STAT_IDX_LSB = 4;
  localparam int STAT_IDX_W   = 6;

  localparam logic [15:0] END_MARK = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BIT   = 3'd3,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // Bus levels {sio_c, sio_d, sio_d_oe} for a given position in the frame.
  // Ack slots release the data line; the driven value there is irrelevant.
  function automatic logic [2:0] sccb_bus(input state_t     st,
                                          input logic [1:0] qtr,
                                          input logic       d_bit,
                                          input logic       ack_slot);
    logic [2:0] v;
    v = 3'b111;
    case (st)
      ST_START: v = {qtr < 2'd2, qtr == 2'd0, 1'b1};
      ST_BIT:   v = {qtr >= 2'd2, ack_slot | d_bit, ~ack_slot};
      ST_STOP:  v = {qtr != 2'd0, qtr >= 2'd2, 1'b1};
      default:  v = 3'b111;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// Camera init table with a one-cycle registered read; anything past the
// populated entries (or past DEPTH) reads back as the end marker.
module cam_cfg_rom
  import cam_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx_i,
  output logic [15:0]      entry_o
);

  logic [15:0] entry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= END_MARK;
    end else if (idx_i >= IDX_W'(DEPTH)) begin
      entry_q <= END_MARK;
    end else begin
      // {register, value}: COM7 soft reset, then CLKRC prescaler
      case (idx_i)
        IDX_W'(0): entry_q <= 16'h1280;
        IDX_W'(1): entry_q <= 16'h1100;
        default:   entry_q <= END_MARK;
      endcase
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/cam_sccb_cfg.sv
// SCCB camera configuration master: Wishbone register slave plus a sequencer
// that replays the init table or single queued commands as 3-phase writes.
module cam_sccb_cfg
  import cam_pkg::*;
#(
  parameter int         CLK_DIV   = 125,
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         ROM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        sio_c,
  output logic        sio_d_o,
  output logic        sio_d_oe,
  output logic        cam_pwdn,
  output logic        cam_reset_n,
  output logic        cfg_done
);

  localparam int IDX_W = $clog2(ROM_DEPTH) + 1;
  localparam int QW    = $clog2(CLK_DIV + 1);
  localparam logic [QW-1:0]    QLOAD   = QW'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(ROM_DEPTH);

  state_t            state_q;
  logic [1:0]        qtr_q;
  logic [3:0]        bitn_q;
  logic [1:0]        byte_q;
  logic [QW-1:0]     qcnt_q;
  logic [IDX_W-1:0]  index_q;
  logic              table_q;
  logic              load_wait_q;
  logic [7:0]        reg_q;
  logic [7:0]        dat_q;
  logic              cfg_done_q;
  logic              dropped_q;
  logic              pwdn_q;
  logic              camrst_q;
  logic              ack_q;
  logic [31:0]       dat_o_q;
  logic              sio_c_q;
  logic              sio_d_q;
  logic              sio_oe_q;

  logic [15:0]       rom_entry;
  logic              wb_req;
  logic              wb_wr;
  logic              wb_rd;
  logic [1:0]        reg_sel;
  logic              busy;
  logic              done;
  logic              cmd_wr;
  logic              start_wr;
  logic              tick;
  logic              timed;
  logic [7:0]        tx_byte;
  logic [2:0]        bit_pos;
  logic              tx_bit;
  logic [2:0]        bus_d;
  logic [31:0]       status_word;
  logic [31:0]       rd_word;
  logic              unused_ok;

  cam_cfg_rom #(
    .DEPTH (ROM_DEPTH),
    .IDX_W (IDX_W)
  ) u_rom (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (index_q),
    .entry_o (rom_entry)
  );

  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16]};

  assign wb_req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_wr    = wb_req & wb_we_i;
  assign wb_rd    = wb_req & ~wb_we_i;
  assign reg_sel  = wb_adr_i[3:2];
  assign busy     = (state_q != ST_IDLE);
  assign done     = cfg_done_q & ~busy;
  assign cmd_wr   = wb_wr && (reg_sel == REG_CMD);
  assign start_wr = wb_wr && (reg_sel == REG_CTRL) && wb_dat_i[CTRL_START];
  assign tick     = (qcnt_q == '0);
  assign timed    = (state_q == ST_START) || (state_q == ST_BIT) ||
                    (state_q == ST_STOP)  || (state_q == ST_GAP);

  always_comb begin
    tx_byte = dat_q;
    case (byte_q)
      2'd0:    tx_byte = DEV_ADDR;
      2'd1:    tx_byte = reg_q;
      default: tx_byte = dat_q;
    endcase
  end

  assign bit_pos = 3'd7 - bitn_q[2:0];
  assign tx_bit  = tx_byte[bit_pos];
  assign bus_d   = sccb_bus(state_q, qtr_q, tx_bit, bitn_q == 4'd8);

  always_comb begin
    status_word            = '0;
    status_word[STAT_BUSY] = busy;
    status_word[STAT_DONE] = done;
    status_word[STAT_DROP] = dropped_q;
    status_word[STAT_IDX_LSB +: STAT_IDX_W] = STAT_IDX_W'(index_q);
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_CTRL:   rd_word = {29'd0, camrst_q, pwdn_q, 1'b0};
      REG_STATUS: rd_word = status_word;
      default:    rd_word = '0;
    endcase
  end

  // Bus levels are registered from the current frame position, so the pins
  // trail the sequencer by one clk; every quarter still spans CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      qtr_q       <= 2'd0;
      bitn_q      <= 4'd0;
      byte_q      <= 2'd0;
      qcnt_q      <= QLOAD;
      index_q     <= '0;
      table_q     <= 1'b0;
      load_wait_q <= 1'b0;
      reg_q       <= 8'd0;
      dat_q       <= 8'd0;
      cfg_done_q  <= 1'b0;
      dropped_q   <= 1'b0;
      pwdn_q      <= 1'b1;
      camrst_q    <= 1'b1;
      ack_q       <= 1'b0;
      dat_o_q     <= '0;
      sio_c_q     <= 1'b1;
      sio_d_q     <= 1'b1;
      sio_oe_q    <= 1'b1;
    end else begin
      ack_q   <= wb_req;
      dat_o_q <= wb_rd ? rd_word : '0;
      if (wb_rd && (reg_sel == REG_STATUS)) dropped_q <= 1'b0;
      if ((cmd_wr || start_wr) && busy) dropped_q <= 1'b1;
      if (wb_wr && (reg_sel == REG_CTRL)) begin
        pwdn_q   <= wb_dat_i[CTRL_PWDN];
        camrst_q <= wb_dat_i[CTRL_RST];
      end

      {sio_c_q, sio_d_q, sio_oe_q} <= bus_d;

      if (timed) qcnt_q <= tick ? QLOAD : (qcnt_q - QW'(1));

      case (state_q)
        ST_IDLE: begin
          if (cmd_wr) begin
            reg_q   <= wb_dat_i[15:8];
            dat_q   <= wb_dat_i[7:0];
            table_q <= 1'b0;
            qtr_q   <= 2'd0;
            qcnt_q  <= QLOAD;
            state_q <= ST_START;
          end else if (start_wr) begin
            index_q     <= '0;
            load_wait_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            table_q     <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!load_wait_q) begin
            load_wait_q <= 1'b1;
          end else if ((rom_entry == END_MARK) || (index_q == IDX_END)) begin
            cfg_done_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            reg_q   <= rom_entry[15:8];
            dat_q   <= rom_entry[7:0];
            qtr_q   <= 2'd0;
            qcnt_q  <= QLOAD;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              bitn_q  <= 4'd0;
              byte_q  <= 2'd0;
              state_q <= ST_BIT;
            end
          end
        end
        ST_BIT: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              if (bitn_q == 4'd8) begin
                bitn_q <= 4'd0;
                if (byte_q == 2'd2) state_q <= ST_STOP;
                else                byte_q  <= byte_q + 2'd1;
              end else begin
                bitn_q <= bitn_q + 4'd1;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd3) state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              if (table_q) begin
                index_q     <= index_q + IDX_W'(1);
                load_wait_q <= 1'b0;
                state_q     <= ST_LOAD;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_dat_o    = dat_o_q;
  assign wb_ack_o    = ack_q;
  assign sio_c       = sio_c_q;
  assign sio_d_o     = sio_d_q;
  assign sio_d_oe    = sio_oe_q;
  assign cam_pwdn    = pwdn_q;
  assign cam_reset_n = ~camrst_q;
  assign cfg_done    = done;

endmodule

// File: tb/tb_cam_sccb_cfg.sv
// Directed bench for cam_sccb_cfg (CLK_DIV=4) with an SCCB bus decoder that
// records every START..STOP frame seen on the pins.
module tb_cam_sccb_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        sio_c, sio_d_o, sio_d_oe;
  logic        cam_pwdn, cam_reset_n, cfg_done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [26:0] OE_EXP = 27'b111111110_111111110_111111110;

  always #5 clk = ~clk;

  cam_sccb_cfg #(
    .CLK_DIV   (4),
    .DEV_ADDR  (8'h42),
    .ROM_DEPTH (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .sio_c       (sio_c),
    .sio_d_o     (sio_d_o),
    .sio_d_oe    (sio_d_oe),
    .cam_pwdn    (cam_pwdn),
    .cam_reset_n (cam_reset_n),
    .cfg_done    (cfg_done)
  );

  // Bus decoder: START = d falls with c high, STOP = d rises with c high,
  // each c rising edge samples one bit (the STOP's own c rise is the last one).
  logic        prev_c = 1'b1;
  logic        prev_d = 1'b1;
  logic [27:0] sh_d   = '0;
  logic [27:0] sh_oe  = '0;
  int          nbits  = 0;
  int          n_stop = 0;
  logic [26:0] frm_d[$];
  logic [26:0] frm_oe[$];
  int          frm_n[$];

  always @(negedge clk) begin
    prev_c <= sio_c;
    prev_d <= sio_d_o;
    if (sio_c === 1'b1 && prev_c === 1'b1 && prev_d === 1'b1 && sio_d_o === 1'b0) begin
      nbits <= 0;
    end else if (sio_c === 1'b1 && prev_c === 1'b1 && prev_d === 1'b0 && sio_d_o === 1'b1) begin
      n_stop <= n_stop + 1;
      frm_d.push_back(sh_d[27:1]);
      frm_oe.push_back(sh_oe[27:1]);
      frm_n.push_back(nbits);
    end else if (sio_c === 1'b1 && prev_c === 1'b0) begin
      sh_d  <= {sh_d[26:0], sio_d_o};
      sh_oe <= {sh_oe[26:0], sio_d_oe};
      nbits <= nbits + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [1:0] sel, input logic [31:0] dat,
                    input string tag, output logic [31:0] rd);
    @(posedge clk);
    #1;
    wb_adr_i = {28'h0, sel, 2'b00};
    wb_dat_i = dat;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd1);
    rd       = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int i, input logic [7:0] r, input logic [7:0] d);
    logic [26:0] f;
    logic [26:0] o;
    check({tag, "_present"}, {31'd0, (i < frm_d.size())}, 32'd1);
    if (i < frm_d.size()) begin
      f = frm_d[i];
      o = frm_oe[i];
      check({tag, "_dev"},  {24'd0, f[26:19]}, 32'h42);
      check({tag, "_reg"},  {24'd0, f[17:10]}, {24'd0, r});
      check({tag, "_dat"},  {24'd0, f[8:1]},   {24'd0, d});
      check({tag, "_oe"},   {5'd0, o},         {5'd0, OE_EXP});
      check({tag, "_bits"}, frm_n[i],          32'd28);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int stop0;
    int nfrm0;
    int k;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus",    {29'd0, sio_c, sio_d_o, sio_d_oe}, 32'd7);
    check("rst_pwdn",   {31'd0, cam_pwdn},    32'd1);
    check("rst_camrst", {31'd0, cam_reset_n}, 32'd0);
    check("rst_done",   {31'd0, cfg_done},    32'd0);
    check("rst_ack",    {31'd0, wb_ack_o},    32'd0);
    check("rst_dat",    wb_dat_o,             32'd0);
    rst = 1'b0;

    wb(1'b0, 2'd2, 32'd0, "rd_status0", rd);
    check("status0", rd, 32'h0);
    wb(1'b0, 2'd0, 32'd0, "rd_ctrl0", rd);
    check("ctrl0", rd, 32'h6);
    wb(1'b0, 2'd3, 32'd0, "rd_unmapped", rd);
    check("unmapped_rd", rd, 32'h0);

    // Held strobe: ack every other cycle
    @(posedge clk);
    #1;
    wb_adr_i = 32'h8;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("b2b_ack", {31'd0, wb_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;

    // CTRL release of camera, unmapped write ignored
    wb(1'b1, 2'd0, 32'h0, "wr_ctrl", rd);
    check("ctrl_pwdn",   {31'd0, cam_pwdn},    32'd0);
    check("ctrl_resetn", {31'd0, cam_reset_n}, 32'd1);
    wb(1'b1, 2'd3, 32'hFFFF_FFFF, "wr_unmapped", rd);
    wb(1'b0, 2'd0, 32'd0, "rd_ctrl1", rd);
    check("ctrl_rd", rd, 32'h0);
    wb(1'b0, 2'd2, 32'd0, "rd_status1", rd);
    check("status_idle", rd, 32'h0);

    // Single command and busy timing: busy falls 480 clk after the ack
    wb(1'b1, 2'd1, 32'h0000_1280, "cmd1", rd);
    wait_cycles(477);
    wb(1'b0, 2'd2, 32'd0, "rd_busy_hi", rd);
    check("busy_at_479", rd, 32'h1);
    wb(1'b0, 2'd2, 32'd0, "rd_busy_lo", rd);
    check("busy_at_481", rd, 32'h0);
    check("cmd1_frames", frm_d.size(), 32'd1);
    check_frame("cmd1", 0, 8'h12, 8'h80);

    // Command while busy is dropped
    wb(1'b1, 2'd1, 32'h0000_3344, "cmd2", rd);
    wait_cycles(100);
    wb(1'b1, 2'd1, 32'h0000_5566, "cmd_drop", rd);
    wait_cycles(600);
    check("drop_frames", frm_d.size(), 32'd2);
    check_frame("cmd2", 1, 8'h33, 8'h44);
    wb(1'b0, 2'd2, 32'd0, "rd_drop1", rd);
    check("dropped_set", rd, 32'h4);
    wb(1'b0, 2'd2, 32'd0, "rd_drop2", rd);
    check("dropped_clr", rd, 32'h0);

    // Init table: two entries then the end marker
    wb(1'b1, 2'd0, 32'h1, "start_tbl", rd);
    k = 0;
    while (cfg_done !== 1'b1 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tbl_done", {31'd0, cfg_done}, 32'd1);
    check("tbl_frames", frm_d.size(), 32'd4);
    check_frame("tbl0", 2, 8'h12, 8'h80);
    check_frame("tbl1", 3, 8'h11, 8'h00);
    wb(1'b0, 2'd2, 32'd0, "rd_tbl", rd);
    check("tbl_status", rd, 32'h22);

    // Reset mid-transaction: bus idles at once, no STOP follows
    stop0 = n_stop;
    nfrm0 = frm_d.size();
    wb(1'b1, 2'd1, 32'h0000_FF55, "cmd_abort", rd);
    wait_cycles(199);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_bus", {29'd0, sio_c, sio_d_o, sio_d_oe}, 32'd7);
    rst = 1'b0;
    wait_cycles(600);
    check("abort_nostop", n_stop, stop0);
    check("abort_frames", frm_d.size(), nfrm0);
    check("abort_pwdn", {31'd0, cam_pwdn}, 32'd1);
    check("abort_done", {31'd0, cfg_done}, 32'd0);
    wb(1'b0, 2'd2, 32'd0, "rd_abort", rd);
    check("abort_status", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_sccb_cfg.md
CAM_SCCB_CFG -- requirements
Module: cam_sccb_cfg

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning clk cycles per SCCB quarter-bit (100 kHz SCCB at 50 MHz).
REQ-002 SHALL have parameter DEV_ADDR, default 8'h42, meaning 8-bit SCCB write address of the camera.
REQ-003 SHALL have parameter ROM_DEPTH, default 64, meaning the number of init-table entries.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-006 SHALL have ports wb_adr_i in 32, wb_dat_i in 32, wb_we_i in 1, wb_cyc_i in 1, wb_stb_i in 1, forming the Wishbone slave inputs.
REQ-007 SHALL have ports wb_dat_o out 32 and wb_ack_o out 1, forming the Wishbone slave outputs.
REQ-008 SHALL have ports sio_c out 1 (SCCB clock), sio_d_o out 1 (SCCB data value) and sio_d_oe out 1 (data drive enable; 0 = release).
REQ-009 SHALL have ports cam_pwdn out 1 (camera power-down) and cam_reset_n out 1 (camera reset, active low).
REQ-010 SHALL have port cfg_done out 1, high when the init table has completed and the block is idle.

Function
REQ-011 SHALL decode wb_adr_i[3:2]: 0 = CTRL (R/W), 1 = CMD (W), 2 = STATUS (R); any other read returns 0 and any other write is ignored.
REQ-012 SHALL assert wb_ack_o for exactly one cycle, on the cycle after a clk edge where stb&cyc&~ack holds; back-to-back accesses ack every other cycle.
REQ-013 SHALL map CTRL bits as: bit0 start table (self-clearing pulse, reads 0), bit1 cam_pwdn (reset 1), bit2 cam reset (reset 1, drives cam_reset_n=~bit2).
REQ-014 SHALL map a CMD write as wb_dat_i[15:8] = register address and [7:0] = data, queued as a single SCCB write.
REQ-015 SHALL map STATUS bits as: bit0 busy, bit1 cfg_done, bit2 dropped (sticky; cleared by a STATUS read), bits[9:4] current table index.
REQ-016 SHALL use an FSM with states IDLE, LOAD, START, BIT, STOP, GAP.
REQ-017 SHALL take CMD in IDLE -> START with the CMD byte pair, or start-table in IDLE -> LOAD with index 0.
REQ-018 SHALL, in LOAD, fetch a ROM entry; entry 16'hFFFF or index == ROM_DEPTH ends the table: cfg_done<=1 and -> IDLE; otherwise -> START.
REQ-019 SHALL define each SCCB bit as 4 quarters of CLK_DIV cycles: sio_c = 0,0,1,1; sio_d changes only at quarter-0 entry.
REQ-020 SHALL perform START with sio_d 1->0 while sio_c=1 (2 quarters), then sio_c->0.
REQ-021 SHALL perform STOP with sio_d=0, sio_c 0->1, then sio_d 0->1 (4 quarters total).
REQ-022 SHALL send each transaction as 3 phases {DEV_ADDR, reg, data}, MSB first, each followed by a don't-care bit with sio_d_oe=0: 27 bits total, 116 quarters including START and STOP.
REQ-023 SHALL hold GAP for 4 quarters after STOP, then go -> LOAD (index+1) in table mode or -> IDLE in CMD mode.
REQ-024 SHALL ignore a CMD write or start-table while busy and set dropped; the ack is still given.
REQ-025 SHALL hold busy=1 in every state except IDLE; cfg_done is cleared on start-table.
REQ-026 SHALL idle the bus at sio_c=1, sio_d_o=1, sio_d_oe=1.

Reset
REQ-027 SHALL, on rst, reset all outputs: wb_ack_o=0, wb_dat_o=0, sio_c=1, sio_d_o=1, sio_d_oe=1, cam_pwdn=1, cam_reset_n=0, cfg_done=0, state=IDLE, index=0, dropped=0.
REQ-028 SHALL abort any transaction when rst arrives mid-transaction, with no STOP generated and the bus idle on the next edge.

Structure
REQ-029 SHALL place the register offsets, STATUS bit positions, the 16'hFFFF end marker and the FSM state encodings in a shared package, cam_pkg.
REQ-030 SHALL place the init table in sub-module cam_cfg_rom (index in, 16-bit entry out, one-cycle registered read); LOAD SHALL wait that cycle.

Verification (CLK_DIV=4: quarter = 4 clk, transaction = 464 clk, plus a 16 clk gap)
REQ-031 SHALL cover: reset, then read STATUS -> wb_dat_o=0, sio_c=1, sio_d_o=1, cam_pwdn=1, cam_reset_n=0.
REQ-032 SHALL cover: CMD write 32'h0000_1280 -> the bus decoder captures bytes 42,12,80 with oe=0 in bits 9/18/27; busy falls 480 clk after the ack.
REQ-033 SHALL cover: ROM with 2 entries then FFFF, CTRL write 1 -> 2 transactions, then cfg_done=1 and STATUS = 32'h0000_0022 (index 2, cfg_done).
REQ-034 SHALL cover: CMD write during a transaction -> ack given, the bus decoder captures no extra transaction, STATUS bit2=1; a second read shows bit2=0.
REQ-035 SHALL cover: rst asserted at clk 200 of a transaction -> sio_c=1, sio_d_o=1, sio_d_oe=1 on the next edge, with no STOP generated.
REQ-036 SHALL cover: CTRL write 32'h0 -> cam_pwdn=0 and cam_reset_n=1; CTRL read returns 32'h0.
